alu_pipe_mul: RTL and testbench
===============================

// Module: alu_pipe_mul
// PURPOSE
// - Parametrised successor of the EXE-stage ALU, for the 32-bit ARM pipeline.
// - Registered output with valid/ready handshakes on the input and output sides.
// - Adds an iterative shift-add multiplier (MUL/MLA) that takes several cycles.
// - Sits in EXE. The hazard/stall logic uses in_ready and busy to freeze ID/EXE.
// PARAMETERS
// - WIDTH     32  datapath width; must be >= 8 and a multiple of MUL_BITS
// - MUL_BITS  4   multiplier bits retired per cycle; must be a power of 2, <= WIDTH
// PORTS
// - clk          in   1      single clock, rising edge
// - rst_n        in   1      asynchronous, active-low reset
// - in_valid     in   1      operation presented this cycle
// - in_ready     out  1      block accepts the op; a transfer is in_valid & in_ready
// - exe_cmd      in   4      opcode: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011,
//                            SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111,
//                            EOR 1000, MUL 1010, MLA 1011
// - val1         in   WIDTH  operand Rn (MUL/MLA: multiplicand)
// - val2         in   WIDTH  operand 2 (MUL/MLA: multiplier)
// - val3         in   WIDTH  MLA accumulator; ignored otherwise
// - c_in         in   1      current C flag
// - out_valid    out  1      result/status_bits valid
// - out_ready    in   1      consumer takes the result; a transfer is out_valid & out_ready
// - result       out  WIDTH  operation result
// - status_bits  out  4      {N,Z,C,V}
// - busy         out  1      multiplier iterating
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, status_bits=0, busy=0,
//   in_ready=0 while rst_n=0. Any in-flight op is discarded; no output is produced for it.
// - in_ready = (state==IDLE) & (~out_valid | out_ready). The output register is a single
//   entry and can refill in the same cycle it drains.
// - FSM IDLE:
//   - A single-cycle op is accepted in cycle T. The result is registered and out_valid=1
//     at T+1, so latency is 1.
//   - Back-to-back ops at throughput 1 are supported while out_ready=1.
//   - Accepting MUL/MLA latches the operands and moves to MUL. acc=val3 for MLA, 0 for MUL.
// - FSM MUL:
//   - busy=1. Each cycle: acc += mcand * mplier[MUL_BITS-1:0], where mcand is WIDTH bits;
//     then mcand <<= MUL_BITS and mplier >>= MUL_BITS.
//   - Stays for WIDTH/MUL_BITS cycles, then enters DONE.
// - FSM DONE:
//   - Loads acc into result and sets out_valid. Moves to IDLE once the output register
//     is empty (~out_valid | out_ready).
//   - MUL latency is WIDTH/MUL_BITS+2 cycles from acceptance to out_valid; 10 at defaults.
// - While out_valid & ~out_ready, result and status_bits hold stable.
// - Arithmetic: all results are truncated to WIDTH bits.
//   - N = result[WIDTH-1]; Z = (result==0).
//   - ADD/ADC: {C,result} = val1 + val2 (+c_in for ADC), computed WIDTH+1 wide.
//     V = signed overflow: (a[msb]==b[msb]) & (r[msb]!=a[msb]).
//   - SUB/SBC: result = val1 - val2 - (SBC ? ~c_in : 0). C = no-borrow, ARM convention.
//     V = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
//   - MOV/MVN/AND/ORR/EOR/MUL/MLA: C=0, V=0.
//   - Undefined opcodes: result=0, status={0,1,0,0}, latency 1.
// - Boundaries:
//   - Multiplier products are low-WIDTH only; overflow wraps silently.
//   - MLA with val2=0 returns val3 after the full latency; there is no early exit.
//   - in_valid while busy is ignored (in_ready=0). The op is not captured and must be held.
//   - out_ready is sampled only while out_valid=1.
// CONFIGURATION
// - Macro ALU_PIPE_MUL_EN:
//   - Defined: multiplier datapath and the MUL/DONE states are present.
//   - Undefined: 1010/1011 decode as undefined opcodes (result=0, status={0,1,0,0},
//     latency 1). busy is tied to 0 and no multiplier logic is synthesised.
// TESTING
// - Reset: rst_n=0 mid-MUL (busy=1) -> out_valid=0, result=0, busy=0 asynchronously;
//   no result appears after release.
// - ADD: val1=0x7FFFFFFF, val2=1, out_ready=1 -> next cycle result=0x80000000, status=1001.
//   SUB: val1=5, val2=5 -> result=0, status=0110.
// - Throughput: 4 back-to-back ADD ops (val1=i, val2=1) with out_ready=1 -> results 1,2,3,4
//   on 4 consecutive cycles, in_ready stays 1.
// - Backpressure: out_ready=0 after an EOR 0xFF^0x0F -> result holds 0xF0, in_ready=0;
//   raise out_ready -> one transfer, in_ready=1 the same cycle.
// - MLA (ALU_PIPE_MUL_EN): val1=0x10000, val2=0x10001, val3=3 -> busy for 8 cycles;
//   out_valid 10 cycles after accept; result=0x00010003, status=0000. An in_valid pulse
//   while busy is not accepted.
// - Without ALU_PIPE_MUL_EN: MUL 6x7 -> latency 1, result=0, status=0100, busy never set.

Source files
------------

// File: rtl/alu_pipe_mul_if.sv
// Handshake bus for the EXE-stage ALU: operation input, result output and busy status.
interface alu_pipe_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       exe_cmd;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] val3;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       status_bits;
  logic             busy;

  modport master (
    output in_valid, exe_cmd, val1, val2, val3, c_in, out_ready,
    input  in_ready, out_valid, result, status_bits, busy
  );

  modport slave (
    input  in_valid, exe_cmd, val1, val2, val3, c_in, out_ready,
    output in_ready, out_valid, result, status_bits, busy
  );
endinterface

// File: rtl/alu_pipe_mul.sv
// EXE-stage ALU with a registered, handshaked output and an optional iterative MUL/MLA unit.
// The multiplier is present only when ALU_PIPE_MUL_EN is defined.
module alu_pipe_mul #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input logic           clk,
  input logic           rst_n,
  alu_pipe_mul_if.slave io
);

  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] CmdMul = 4'b1010;
  localparam logic [3:0] CmdMla = 4'b1011;

  localparam int unsigned Iters = WIDTH / MUL_BITS;
  localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle} state_e;
`endif

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       status_q;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_undef;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;

  assign io.in_ready = rst_n & (state_q == StIdle) & (~out_valid_q | io.out_ready);
  assign accept      = io.in_valid & io.in_ready;

  // Single-cycle datapath; subtraction uses a + ~b + carry so C is the ARM no-borrow flag.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_undef = 1'b0;
    sum       = '0;
    case (io.exe_cmd)
      CmdMov: alu_res = io.val2;
      CmdMvn: alu_res = ~io.val2;
      CmdAdd, CmdAdc: begin
        sum     = {1'b0, io.val1} + {1'b0, io.val2}
                  + {{WIDTH{1'b0}}, (io.exe_cmd == CmdAdc) & io.c_in};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (io.val1[WIDTH-1] == io.val2[WIDTH-1]) &
                  (alu_res[WIDTH-1] != io.val1[WIDTH-1]);
      end
      CmdSub, CmdSbc: begin
        sum     = {1'b0, io.val1} + {1'b0, ~io.val2}
                  + {{WIDTH{1'b0}}, (io.exe_cmd == CmdSbc) ? io.c_in : 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (io.val1[WIDTH-1] != io.val2[WIDTH-1]) &
                  (alu_res[WIDTH-1] != io.val1[WIDTH-1]);
      end
      CmdAnd: alu_res = io.val1 & io.val2;
      CmdOrr: alu_res = io.val1 | io.val2;
      CmdEor: alu_res = io.val1 ^ io.val2;
      default: alu_undef = 1'b1;
    endcase
    alu_flags = alu_undef ? 4'b0100 : {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
  end

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] pp;

  assign is_mul  = (io.exe_cmd == CmdMul) | (io.exe_cmd == CmdMla);
  assign pp      = mcand_q * WIDTH'(mplier_q[MUL_BITS-1:0]);
  assign io.busy = busy_q;
`else
  assign is_mul  = 1'b0;
  assign io.busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
`ifdef ALU_PIPE_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
`endif
    end else begin
      if (out_valid_q && io.out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (accept && !is_mul) begin
            result_q    <= alu_res;
            status_q    <= alu_flags;
            out_valid_q <= 1'b1;
          end
`ifdef ALU_PIPE_MUL_EN
          if (accept && is_mul) begin
            acc_q    <= (io.exe_cmd == CmdMla) ? io.val3 : '0;
            mcand_q  <= io.val1;
            mplier_q <= io.val2;
            cnt_q    <= CntW'(Iters - 1);
            busy_q   <= 1'b1;
            state_q  <= StMul;
          end
`endif
        end
`ifdef ALU_PIPE_MUL_EN
        StMul: begin
          acc_q    <= acc_q + pp;
          mcand_q  <= mcand_q << MUL_BITS;
          mplier_q <= mplier_q >> MUL_BITS;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Wait for a free output slot so a stalled earlier result is never overwritten.
          if (!out_valid_q || io.out_ready) begin
            result_q    <= acc_q;
            status_q    <= {acc_q[WIDTH-1], acc_q == '0, 2'b00};
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.result      = result_q;
  assign io.status_bits = status_q;

endmodule

// File: tb/tb_alu_pipe_mul.sv
// Directed self-checking bench for alu_pipe_mul; the MUL/MLA checks follow ALU_PIPE_MUL_EN.
module tb_alu_pipe_mul;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_pipe_mul_if #(.WIDTH(32)) bus_if ();

  alu_pipe_mul #(
    .WIDTH   (32),
    .MUL_BITS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one cycle (caller ensures in_ready is high).
  task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] v3, input logic cin);
    bus_if.exe_cmd  = cmd;
    bus_if.val1     = v1;
    bus_if.val2     = v2;
    bus_if.val3     = v3;
    bus_if.c_in     = cin;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    int cycles;
    int busy_cycles;
    int stray;
    n_checks = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.exe_cmd   = 4'b0000;
    bus_if.val1      = '0;
    bus_if.val2      = '0;
    bus_if.val3      = '0;
    bus_if.c_in      = 1'b0;
    bus_if.out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_result", bus_if.result, 32'd0);
    check("rst_status", 32'(bus_if.status_bits), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(bus_if.in_ready), 32'd1);

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
    check("add_valid", 32'(bus_if.out_valid), 32'd1);
    check("add_result", bus_if.result, 32'h8000_0000);
    check("add_status", 32'(bus_if.status_bits), 32'b1001);

    issue(4'b0100, 32'd5, 32'd5, 32'h0, 1'b0);
    check("sub_result", bus_if.result, 32'd0);
    check("sub_status", 32'(bus_if.status_bits), 32'b0110);

    issue(4'b0011, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
    check("adc_result", bus_if.result, 32'd0);
    check("adc_status", 32'(bus_if.status_bits), 32'b0110);

    issue(4'b0101, 32'h0, 32'h0, 32'h0, 1'b0);
    check("sbc_result", bus_if.result, 32'hFFFF_FFFF);
    check("sbc_status", 32'(bus_if.status_bits), 32'b1000);

    issue(4'b1001, 32'h0, 32'h0, 32'h0, 1'b0);
    check("mvn_result", bus_if.result, 32'hFFFF_FFFF);
    check("mvn_status", 32'(bus_if.status_bits), 32'b1000);

    issue(4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1);
    check("undef_result", bus_if.result, 32'd0);
    check("undef_status", 32'(bus_if.status_bits), 32'b0100);

    // Back-to-back ADDs at full throughput.
    bus_if.exe_cmd  = 4'b0010;
    bus_if.val2     = 32'd1;
    bus_if.c_in     = 1'b0;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.val1 = 32'(i);
      #1;
      check($sformatf("tput_in_ready%0d", i), 32'(bus_if.in_ready), 32'd1);
      step();
      check($sformatf("tput_valid%0d", i), 32'(bus_if.out_valid), 32'd1);
      check($sformatf("tput_result%0d", i), bus_if.result, 32'(i + 1));
    end
    bus_if.in_valid = 1'b0;
    step();
    check("tput_drained", 32'(bus_if.out_valid), 32'd0);

    // Backpressure on an EOR result.
    bus_if.out_ready = 1'b0;
    issue(4'b1000, 32'hFF, 32'h0F, 32'h0, 1'b0);
    check("bp_result", bus_if.result, 32'hF0);
    check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
    step();
    check("bp_hold_valid", 32'(bus_if.out_valid), 32'd1);
    check("bp_hold_result", bus_if.result, 32'hF0);
    check("bp_hold_status", 32'(bus_if.status_bits), 32'b0000);
    bus_if.out_ready = 1'b1;
    #1;
    check("bp_ready_same_cycle", 32'(bus_if.in_ready), 32'd1);
    step();
    check("bp_one_transfer", 32'(bus_if.out_valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
    // MLA with a stray in_valid pulse while busy.
    issue(4'b1011, 32'h0001_0000, 32'h0001_0001, 32'd3, 1'b0);
    cycles      = 1;
    busy_cycles = 0;
    while (!bus_if.out_valid && cycles < 40) begin
      if (bus_if.busy) busy_cycles++;
      if (cycles == 3) begin
        bus_if.exe_cmd  = 4'b0010;
        bus_if.in_valid = 1'b1;
        check("mla_busy_in_ready", 32'(bus_if.in_ready), 32'd0);
      end
      step();
      bus_if.in_valid = 1'b0;
      cycles++;
    end
    check("mla_latency", 32'(cycles), 32'd10);
    check("mla_busy_cycles", 32'(busy_cycles), 32'd8);
    check("mla_result", bus_if.result, 32'h0001_0003);
    check("mla_status", 32'(bus_if.status_bits), 32'b0000);
    step();
    check("mla_no_stray_op", 32'(bus_if.out_valid), 32'd0);

    issue(4'b1010, 32'd6, 32'd7, 32'hDEAD, 1'b0);
    cycles = 1;
    while (!bus_if.out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    check("mul_latency", 32'(cycles), 32'd10);
    check("mul_result", bus_if.result, 32'd42);
    step();

    // Reset in the middle of a multiply.
    issue(4'b1010, 32'd3, 32'd9, 32'h0, 1'b0);
    step();
    step();
    check("rst_mid_busy_before", 32'(bus_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_mid_result", bus_if.result, 32'd0);
    check("rst_mid_busy", 32'(bus_if.busy), 32'd0);
    step();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus_if.out_valid || bus_if.busy) stray++;
    end
    check("rst_mid_no_result", 32'(stray), 32'd0);
`else
    issue(4'b1010, 32'd6, 32'd7, 32'h0, 1'b0);
    check("nomul_valid", 32'(bus_if.out_valid), 32'd1);
    check("nomul_result", bus_if.result, 32'd0);
    check("nomul_status", 32'(bus_if.status_bits), 32'b0100);
    check("nomul_busy", 32'(bus_if.busy), 32'd0);
    step();
    check("nomul_drained", 32'(bus_if.out_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
